// File: rtl/mc_path_gen_if.sv
// Control inputs and terminal-price path stream of the Monte Carlo path generator.
interface mc_path_gen_if;
    logic               start;
    logic               abort;
    logic        [11:0] S0;
    logic signed [7:0]  mu;
    logic        [7:0]  sigma;
    logic        [11:0] path;
    logic               path_valid;
    logic               busy;
    logic               done;

    // Controller side: issues runs and consumes the path stream.
    modport master (
        output start, abort, S0, mu, sigma,
        input  path, path_valid, busy, done
    );

    // Generator side.
    modport slave (
        input  start, abort, S0, mu, sigma,
        output path, path_valid, busy, done
    );
endinterface

// File: rtl/mc_path_gen.sv
// Monte Carlo terminal-price path source: STEPS-step saturating random walk per path, N_PATHS per run.
// Optional MC_PATH_GEN_ANTITHETIC_EN: odd paths replay the negated draws of the preceding even path.
module mc_path_gen #(
    parameter int unsigned STEPS   = 16,
    parameter int unsigned N_PATHS = 1024,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_path_gen_if.slave bus
);
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned PATH_W = (N_PATHS > 1) ? $clog2(N_PATHS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [PATH_W-1:0] PATH_LAST = PATH_W'(N_PATHS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One Galois step, taps x^16+x^14+x^13+x^11 (right-shifting form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Approximate Gaussian draw: nibble sum re-centred to -30..+30.
    function automatic logic signed [6:0] lfsr_draw(input logic [15:0] val);
        logic [6:0] nib_sum;
        nib_sum   = {3'b000, val[3:0]} + {3'b000, val[7:4]}
                  + {3'b000, val[11:8]} + {3'b000, val[15:12]};
        lfsr_draw = $signed(nib_sum - 7'd30);
    endfunction

    // One walk step with clamping to the 12-bit price range.
    function automatic logic [11:0] walk_step(
        input logic        [11:0] acc,
        input logic signed [7:0]  drift,
        input logic        [7:0]  scale,
        input logic signed [6:0]  z
    );
        logic signed [14:0] prod;
        logic signed [14:0] scaled;
        logic signed [14:0] s;
        prod   = $signed({7'b0000000, scale}) * $signed({{8{z[6]}}, z});
        scaled = prod >>> 4;
        s      = $signed({3'b000, acc}) + $signed({{7{drift[7]}}, drift}) + scaled;
        if (s[14]) begin
            walk_step = 12'd0;
        end else if (|s[13:12]) begin
            walk_step = 12'd4095;
        end else begin
            walk_step = s[11:0];
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        lfsr_r;
    logic [15:0]        lfsr_nxt_s;
    logic [15:0]        lfsr_adv_s;
    logic [15:0]        lfsr_run_s;
    logic [11:0]        acc_r;
    logic [11:0]        acc_nxt_s;
    logic [11:0]        acc_step_s;
    logic [STEP_W-1:0]  step_r;
    logic [STEP_W-1:0]  step_nxt_s;
    logic [PATH_W-1:0]  path_cnt_r;
    logic [PATH_W-1:0]  path_cnt_nxt_s;
    logic [11:0]        s0_r;
    logic signed [7:0]  mu_r;
    logic [7:0]         sigma_r;
    logic               load_s;
    logic               advance_s;
    logic signed [6:0]  z_s;
    logic [11:0]        path_r;
    logic [11:0]        path_nxt_s;
    logic               path_valid_r;
    logic               path_valid_nxt_s;
    logic               busy_r;
    logic               done_r;

`ifdef MC_PATH_GEN_ANTITHETIC_EN
    logic signed [6:0]  z_buf_r [STEPS];
    logic               odd_s;

    // Draw selection: fresh draws on even paths, negated replay with frozen lfsr on odd paths.
    always_comb begin
        odd_s      = path_cnt_r[0];
        lfsr_adv_s = lfsr_step(lfsr_r);
        if (odd_s) begin
            z_s        = -z_buf_r[step_r];
            lfsr_run_s = lfsr_r;
        end else begin
            z_s        = lfsr_draw(lfsr_adv_s);
            lfsr_run_s = lfsr_adv_s;
        end
        acc_step_s = walk_step(acc_r, mu_r, sigma_r, z_s);
    end

    // Draw buffer filled during even paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                z_buf_r[i] <= 7'sd0;
            end
        end else if (advance_s && !odd_s) begin
            z_buf_r[step_r] <= z_s;
        end else begin
            z_buf_r <= z_buf_r;
        end
    end
`else
    // Draw selection: every step consumes a fresh lfsr value.
    always_comb begin
        lfsr_adv_s = lfsr_step(lfsr_r);
        z_s        = lfsr_draw(lfsr_adv_s);
        lfsr_run_s = lfsr_adv_s;
        acc_step_s = walk_step(acc_r, mu_r, sigma_r, z_s);
    end
`endif

    // Next-state and datapath-update decode; abort takes priority over any step in RUN.
    always_comb begin
        state_nxt_s      = state_r;
        lfsr_nxt_s       = lfsr_r;
        acc_nxt_s        = acc_r;
        step_nxt_s       = step_r;
        path_cnt_nxt_s   = path_cnt_r;
        load_s           = 1'b0;
        advance_s        = 1'b0;
        path_nxt_s       = 12'd0;
        path_valid_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s    = RUN;
                    load_s         = 1'b1;
                    acc_nxt_s      = bus.S0;
                    step_nxt_s     = '0;
                    path_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    advance_s  = 1'b1;
                    lfsr_nxt_s = lfsr_run_s;
                    if (step_r == STEP_LAST) begin
                        path_nxt_s       = acc_step_s;
                        path_valid_nxt_s = 1'b1;
                        acc_nxt_s        = s0_r;
                        step_nxt_s       = '0;
                        path_cnt_nxt_s   = path_cnt_r + {{(PATH_W-1){1'b0}}, 1'b1};
                        if (path_cnt_r == PATH_LAST) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        acc_nxt_s  = acc_step_s;
                        step_nxt_s = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, walk registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            lfsr_r       <= SEED;
            acc_r        <= 12'd0;
            step_r       <= '0;
            path_cnt_r   <= '0;
            path_r       <= 12'd0;
            path_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lfsr_r       <= lfsr_nxt_s;
            acc_r        <= acc_nxt_s;
            step_r       <= step_nxt_s;
            path_cnt_r   <= path_cnt_nxt_s;
            path_r       <= path_nxt_s;
            path_valid_r <= path_valid_nxt_s;
            busy_r       <= (state_nxt_s == RUN);
            done_r       <= (state_r == DONE);
        end
    end

    // Run parameters captured on an accepted start and held for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_r    <= 12'd0;
            mu_r    <= 8'sd0;
            sigma_r <= 8'd0;
        end else if (load_s) begin
            s0_r    <= bus.S0;
            mu_r    <= bus.mu;
            sigma_r <= bus.sigma;
        end else begin
            s0_r    <= s0_r;
            mu_r    <= mu_r;
            sigma_r <= sigma_r;
        end
    end

    assign bus.path       = path_r;
    assign bus.path_valid = path_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_mc_path_gen.sv
// Randomized self-checking bench for mc_path_gen against a step-level arithmetic reference model.
module tb_mc_path_gen;
    localparam int          STEPS   = 16;
    localparam int          N_PATHS = 1024;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mc_path_gen_if bus();

    mc_path_gen #(
        .STEPS   (STEPS),
        .N_PATHS (N_PATHS),
        .SEED    (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_lfsr;
    int m_zbuf [STEPS];
    int last_obs;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_next(input int x);
        if (x % 2 == 1) return (x / 2) ^ 'hB400;
        return x / 2;
    endfunction

    function automatic int m_draw(input int x);
        return (x % 16) + ((x / 16) % 16) + ((x / 256) % 16) + ((x / 4096) % 16) - 30;
    endfunction

    function automatic int m_walk(input int acc, input int mu, input int sigma, input int z);
        int p;
        int s;
        p = sigma * z;
        s = acc + mu + ((p >= 0) ? p / 16 : -((-p + 15) / 16));
        if (s < 0) return 0;
        if (s > 4095) return 4095;
        return s;
    endfunction

    task automatic run_paths(input int s0, input int mu, input int sigma, input int n_paths, input bit do_abort);
        int acc;
        int z;
        int quiet;
        bit odd;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
        int lfsr_before;
        int prev_path;
        prev_path = 0;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.S0    = 12'(s0);
        bus.mu    = 8'(mu);
        bus.sigma = 8'(sigma);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.S0    = 12'($urandom);
        bus.mu    = 8'($urandom);
        bus.sigma = 8'($urandom);
        check_eq("busy_after_start", int'(bus.busy), 1);
        acc = s0;
        for (int p = 0; p < n_paths; p++) begin
            odd = 1'b0;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
            odd = (p % 2 == 1);
            lfsr_before = m_lfsr;
`endif
            for (int k = 0; k < STEPS; k++) begin
                @(posedge clk); #1;
                if (odd) begin
                    z = -m_zbuf[k];
                end else begin
                    m_lfsr    = m_next(m_lfsr);
                    z         = m_draw(m_lfsr);
                    m_zbuf[k] = z;
                end
                acc = m_walk(acc, mu, sigma, z);
                if (k < STEPS - 1) begin
                    check_eq("gap_zero", int'({bus.path_valid, bus.path}), 0);
                end else begin
                    check_eq("path_valid", int'(bus.path_valid), 1);
                    check_eq("path", int'(bus.path), acc);
                    last_obs = int'(bus.path);
`ifdef MC_PATH_GEN_ANTITHETIC_EN
                    if (odd) begin
                        check_eq("lfsr_frozen", int'(dut.lfsr_r), lfsr_before);
                        if (s0 == 2048 && mu == 0 && sigma == 64)
                            check_eq("pair_sum", prev_path + int'(bus.path), 4096);
                    end
                    prev_path = int'(bus.path);
`endif
                    acc = s0;
                end
            end
        end
        if (do_abort) begin
            @(negedge clk);
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            check_eq("abort_busy", int'(bus.busy), 0);
            check_eq("abort_out", int'({bus.path_valid, bus.path}), 0);
            check_eq("abort_done", int'(bus.done), 0);
            quiet = 0;
            repeat (2 * STEPS) begin
                @(posedge clk); #1;
                if (bus.path_valid || bus.done || bus.busy) quiet++;
            end
            check_eq("abort_quiet", quiet, 0);
        end else begin
            @(posedge clk); #1;
            check_eq("done_pulse", int'(bus.done), 1);
            check_eq("done_busy", int'(bus.busy), 0);
            check_eq("done_out", int'({bus.path_valid, bus.path}), 0);
            @(posedge clk); #1;
            check_eq("done_single", int'(bus.done), 0);
            check_eq("idle_busy", int'(bus.busy), 0);
        end
        check_eq("lfsr_track", int'(dut.lfsr_r), m_lfsr);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.S0    = 12'd0;
        bus.mu    = 8'sd0;
        bus.sigma = 8'd0;
        m_lfsr    = int'(SEED);
        last_obs  = 0;

        #1;
        check_eq("reset_outputs", int'({bus.busy, bus.done, bus.path_valid, bus.path}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("reset_lfsr", int'(dut.lfsr_r), 'hACE1);

        // Full flat run, with abort raised alongside start in IDLE.
        bus.abort = 1'b1;
        run_paths(2000, 0, 0, N_PATHS, 1'b0);
        check_eq("flat_const", last_obs, 2000);

        run_paths(1000, 10, 0, 4, 1'b1);
        check_eq("drift_up_const", last_obs, 1160);
        run_paths(1000, -10, 0, 4, 1'b1);
        check_eq("drift_down_const", last_obs, 840);
        run_paths(4000, 127, 0, 3, 1'b1);
        check_eq("sat_high_const", last_obs, 4095);
        run_paths(100, -128, 0, 3, 1'b1);
        check_eq("sat_low_const", last_obs, 0);

`ifdef MC_PATH_GEN_ANTITHETIC_EN
        run_paths(2048, 0, 64, 20, 1'b1);
`endif

        // Abort after the third path, then a complete randomized run.
        run_paths(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)), 3, 1'b1);
        run_paths(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)), N_PATHS, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_paths(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)), int'($urandom_range(2, 6)), 1'b1);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.S0    = 12'd3000;
        bus.mu    = 8'sd5;
        bus.sigma = 8'd40;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrun_reset_outputs", int'({bus.busy, bus.done, bus.path_valid, bus.path}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("midrun_reset_lfsr", int'(dut.lfsr_r), 'hACE1);
        check_eq("midrun_reset_busy", int'(bus.busy), 0);
        m_lfsr = int'(SEED);
        run_paths(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)), 4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
